instruction_fetch_sequencer: RTL and testbench
==============================================

// Module: instruction_fetch_sequencer
// PURPOSE
//  Sequences the instruction ROM: owns the program counter and drives the ROM address.
//  Captures the ROM's combinational read data into an instruction register.
//  Hands that register to the decode stage over a valid/ready handshake.
//  Handles jumps, halt and backpressure. Sits between the ROM and the decoder in the microcontroller core.
// PARAMETERS
//  ADDR_WIDTH    8      ROM address width; PC width
//  INSTR_WIDTH   16     ROM instruction word width
//  RESET_VECTOR  8'h00  PC value after reset
// PORTS
//  clk                      in   1            single core clock; all state on rising edge
//  rst                      in   1            asynchronous, active-high reset
//  Address_Instruction_Bus  out  ADDR_WIDTH   ROM address; equals PC register directly
//  Instruction              in   INSTR_WIDTH  ROM read data, combinational from address
//  Jump_En                  in   1            redirect fetch to Jump_Addr this cycle
//  Jump_Addr                in   ADDR_WIDTH   jump target
//  Halt                     in   1            stop fetching (decoder executed HALT)
//  IR_Ready                 in   1            decoder accepts IR this cycle
//  IR_Valid                 out  1            Instruction_Reg holds a live instruction
//  Instruction_Reg          out  INSTR_WIDTH  fetched instruction
//  IR_PC                    out  ADDR_WIDTH   address Instruction_Reg was fetched from
//  Halted                   out  1            high while in S_HALT
//  Wrap                     out  1            one-cycle pulse: PC advanced from all-ones to 0
// BEHAVIOUR
//  Reset (async, immediate):
//   - PC=RESET_VECTOR; Instruction_Reg=0; IR_PC=0; IR_Valid=0; Halted=0; Wrap=0; state=S_BOOT.
//  States:
//   - S_BOOT: one cycle, no capture, IR_Valid=0, then S_RUN.
//   - S_RUN: normal fetch.
//   - S_HALT: PC and IR frozen, IR_Valid=0, Halted=1.
//  advance = (state==S_RUN) && (!IR_Valid || IR_Ready).
//  On advance, all at the same edge:
//   - Instruction_Reg<=Instruction; IR_PC<=PC; IR_Valid<=1; PC<=PC+1.
//   - Fetch latency: address presented in cycle N, instruction visible with IR_Valid in N+1.
//   - Full throughput (1 instr/cycle) while IR_Ready=1.
//  Backpressure: IR_Valid=1 && IR_Ready=0 -> PC, Instruction_Reg, IR_PC and IR_Valid hold unchanged.
//  Jump_En=1 (any state except S_BOOT):
//   - PC<=Jump_Addr; IR_Valid<=0 (current IR flushed, even if IR_Ready=1); state<=S_RUN.
//   - Target instruction is visible 2 cycles after the Jump_En cycle.
//   - Jump_En from S_HALT is the only non-reset exit from halt.
//  Halt=1 in S_RUN with Jump_En=0: state<=S_HALT; IR_Valid<=0; PC unchanged (no increment).
//  Priority, highest first: rst > Jump_En > Halt > advance/stall.
//  Halt or Jump_En in S_BOOT: ignored.
//  PC arithmetic: modulo 2^ADDR_WIDTH; 8'hFF+1 -> 8'h00 with Wrap=1 for that one cycle.
//   - Wrap is 0 in all other cycles, including jumps to 0.
//  Reset mid-stall or mid-halt: all state returns to the reset values at once; no partial handshake survives.
// STRUCTURE
//  Shared package (fetch_pkg):
//   - state encoding S_BOOT/S_RUN/S_HALT (2-bit).
//   - ADDR_WIDTH/INSTR_WIDTH defaults.
//   - RESET_VECTOR constant.
//  Sub-module program_counter:
//   - PC register with load (jump), increment enable and wrap-pulse output.
//  Top level holds the FSM, IR/IR_PC/IR_Valid registers and the priority logic.
// TESTING (ROM model: Instruction = {8'hA5, address})
//  1. Reset release, IR_Ready=1 -> IR_Valid rises 2 cycles after release; IR_PC=0,1,2,...;
//     Instruction_Reg=16'hA500,16'hA501,... one per cycle.
//  2. IR_Ready=0 for 3 cycles while IR_PC=3 -> Instruction_Reg/IR_PC/Address_Instruction_Bus (=4) held;
//     resume delivers 16'hA503 once, then 16'hA504.
//  3. Jump_En=1, Jump_Addr=8'h40 while IR_Valid=1 -> next cycle IR_Valid=0, address=8'h40;
//     following cycle Instruction_Reg=16'hA540, IR_PC=8'h40.
//  4. Halt=1 at PC=8'h10 -> Halted=1, IR_Valid=0, address stays 8'h10 for 5 cycles;
//     then Jump_En to 8'h20 -> Halted=0, fetch resumes at 8'h20.
//  5. Jump to 8'hFE, IR_Ready=1 -> IR_PC FE,FF,00; Wrap=1 exactly in the cycle PC goes FF->00.
//  6. Jump_En and Halt asserted together -> jump taken, Halted stays 0;
//     rst asserted mid-stall -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_t;

  localparam int unsigned DEF_ADDR_WIDTH   = 8;
  localparam int unsigned DEF_INSTR_WIDTH  = 16;
  localparam logic [7:0]  DEF_RESET_VECTOR = 8'h00;

endpackage

// File: rtl/instruction_fetch_sequencer_program_counter.sv
// Program counter: jump load, increment enable, one-cycle wrap pulse.
module program_counter
  import fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = DEF_RESET_VECTOR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  wrap
);

  // PC update: load beats increment; wrap flags only an increment out of all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc   <= RESET_VECTOR;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        pc <= load_addr;
      end else if (inc) begin
        pc   <= pc + 1'b1;
        wrap <= (pc == '1);
      end
    end
  end

endmodule

// File: rtl/instruction_fetch_sequencer.sv
// Instruction fetch sequencer: drives the ROM address, captures the read
// data into the instruction register and hands it to decode via valid/ready.
module instruction_fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned           INSTR_WIDTH  = DEF_INSTR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = DEF_RESET_VECTOR
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [ADDR_WIDTH-1:0]  Address_Instruction_Bus,
  input  logic [INSTR_WIDTH-1:0] Instruction,
  input  logic                   Jump_En,
  input  logic [ADDR_WIDTH-1:0]  Jump_Addr,
  input  logic                   Halt,
  input  logic                   IR_Ready,
  output logic                   IR_Valid,
  output logic [INSTR_WIDTH-1:0] Instruction_Reg,
  output logic [ADDR_WIDTH-1:0]  IR_PC,
  output logic                   Halted,
  output logic                   Wrap
);

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  advance;
  logic                  jump_take;
  logic                  pc_inc;

  // Priority decode shared by the FSM and the program counter
  always_comb begin
    advance   = (state == S_RUN) && (!IR_Valid || IR_Ready);
    jump_take = Jump_En && (state != S_BOOT);
    pc_inc    = advance && !Jump_En && !Halt;
  end

  program_counter #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc (
    .clk       (clk),
    .rst       (rst),
    .load      (jump_take),
    .load_addr (Jump_Addr),
    .inc       (pc_inc),
    .pc        (pc),
    .wrap      (Wrap)
  );

  assign Address_Instruction_Bus = pc;

  // FSM plus instruction register, its PC tag and the valid/halted flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_BOOT;
      Instruction_Reg <= '0;
      IR_PC           <= '0;
      IR_Valid        <= 1'b0;
      Halted          <= 1'b0;
    end else begin
      case (state)
        S_BOOT: begin
          state <= S_RUN;
        end
        default: begin
          if (Jump_En) begin
            state    <= S_RUN;
            IR_Valid <= 1'b0;
            Halted   <= 1'b0;
          end else if (state == S_HALT) begin
            Halted <= 1'b1;
          end else if (Halt) begin
            state    <= S_HALT;
            IR_Valid <= 1'b0;
            Halted   <= 1'b1;
          end else if (advance) begin
            Instruction_Reg <= Instruction;
            IR_PC           <= pc;
            IR_Valid        <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Self-checking bench for instruction_fetch_sequencer with a ROM model
// returning {8'hA5, address} and a scoreboard of expected deliveries.
module tb_instruction_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  Address_Instruction_Bus;
  logic [15:0] Instruction;
  logic        Jump_En = 1'b0;
  logic [7:0]  Jump_Addr = 8'h00;
  logic        Halt = 1'b0;
  logic        IR_Ready = 1'b1;
  logic        IR_Valid;
  logic [15:0] Instruction_Reg;
  logic [7:0]  IR_PC;
  logic        Halted;
  logic        Wrap;

  int checks = 0;
  int passed = 0;
  bit sb_on = 1'b0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  assign Instruction = {8'hA5, Address_Instruction_Bus};

  instruction_fetch_sequencer #(
    .ADDR_WIDTH   (8),
    .INSTR_WIDTH  (16),
    .RESET_VECTOR (8'h00)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .Address_Instruction_Bus (Address_Instruction_Bus),
    .Instruction             (Instruction),
    .Jump_En                 (Jump_En),
    .Jump_Addr               (Jump_Addr),
    .Halt                    (Halt),
    .IR_Ready                (IR_Ready),
    .IR_Valid                (IR_Valid),
    .Instruction_Reg         (Instruction_Reg),
    .IR_PC                   (IR_PC),
    .Halted                  (Halted),
    .Wrap                    (Wrap)
  );

  // Scoreboard: every accepted (not flushed) instruction must match the next expected address
  always @(negedge clk) begin
    if (sb_on && !rst && IR_Valid && IR_Ready && !Jump_En && !Halt) begin
      logic [7:0] a;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_underflow: got IR_PC=%h instr=%h, expected nothing", IR_PC, Instruction_Reg);
      end else begin
        a = exp_q.pop_front();
        if (IR_PC !== a || Instruction_Reg !== {8'hA5, a})
          $display("FAIL sb_deliver: got IR_PC=%h instr=%h, expected IR_PC=%h instr=%h",
                   IR_PC, Instruction_Reg, a, {8'hA5, a});
        else passed++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_sb_empty(input string name);
    #1;
    checks++;
    if (exp_q.size() !== 0) $display("FAIL %s_sb_left: got %0d pending, expected 0", name, exp_q.size());
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    IR_Ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({Address_Instruction_Bus, IR_Valid, Instruction_Reg, IR_PC, Halted, Wrap} !== '0)
      $display("FAIL reset_state: got addr=%h v=%b ir=%h irpc=%h halted=%b wrap=%b, expected all 0",
               Address_Instruction_Bus, IR_Valid, Instruction_Reg, IR_PC, Halted, Wrap);
    else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 3; i++) exp_q.push_back(8'(i));
    sb_on = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    checks++;
    if (IR_Valid !== 1'b0 || Address_Instruction_Bus !== 8'h00)
      $display("FAIL boot_cycle: got v=%b addr=%h, expected v=0 addr=00", IR_Valid, Address_Instruction_Bus);
    else passed++;
    tick();
    @(negedge clk);
    checks++;
    if (IR_Valid !== 1'b1 || Address_Instruction_Bus !== 8'h01)
      $display("FAIL first_fetch: got v=%b addr=%h, expected v=1 addr=01", IR_Valid, Address_Instruction_Bus);
    else passed++;
    repeat (2) begin
      tick();
      @(negedge clk);
    end
    test_sb_empty("stream");
  endtask

  task automatic test_backpressure();
    tick();
    IR_Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (IR_Valid !== 1'b1 || IR_PC !== 8'h03 || Instruction_Reg !== 16'hA503 || Address_Instruction_Bus !== 8'h04)
        $display("FAIL stall_hold: got v=%b irpc=%h ir=%h addr=%h, expected v=1 irpc=03 ir=A503 addr=04",
                 IR_Valid, IR_PC, Instruction_Reg, Address_Instruction_Bus);
      else passed++;
      tick();
    end
    exp_q.push_back(8'h03);
    exp_q.push_back(8'h04);
    IR_Ready = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    test_sb_empty("backpressure");
  endtask

  task automatic test_jump();
    tick();
    Jump_En = 1'b1;
    Jump_Addr = 8'h40;
    tick();
    Jump_En = 1'b0;
    @(negedge clk);
    checks++;
    if (IR_Valid !== 1'b0 || Address_Instruction_Bus !== 8'h40)
      $display("FAIL jump_flush: got v=%b addr=%h, expected v=0 addr=40", IR_Valid, Address_Instruction_Bus);
    else passed++;
    exp_q.push_back(8'h40);
    exp_q.push_back(8'h41);
    tick();
    @(negedge clk);
    checks++;
    if (Instruction_Reg !== 16'hA540 || IR_PC !== 8'h40)
      $display("FAIL jump_target: got ir=%h irpc=%h, expected ir=A540 irpc=40", Instruction_Reg, IR_PC);
    else passed++;
    tick();
    @(negedge clk);
    test_sb_empty("jump");
  endtask

  task automatic test_halt();
    tick();
    Jump_En = 1'b1;
    Jump_Addr = 8'h10;
    tick();
    Jump_En = 1'b0;
    Halt = 1'b1;
    tick();
    Halt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (Halted !== 1'b1 || IR_Valid !== 1'b0 || Address_Instruction_Bus !== 8'h10)
        $display("FAIL halt_hold: got halted=%b v=%b addr=%h, expected halted=1 v=0 addr=10",
                 Halted, IR_Valid, Address_Instruction_Bus);
      else passed++;
      tick();
    end
    Jump_En = 1'b1;
    Jump_Addr = 8'h20;
    tick();
    Jump_En = 1'b0;
    @(negedge clk);
    checks++;
    if (Halted !== 1'b0 || Address_Instruction_Bus !== 8'h20)
      $display("FAIL halt_exit: got halted=%b addr=%h, expected halted=0 addr=20", Halted, Address_Instruction_Bus);
    else passed++;
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h21);
    repeat (2) begin
      tick();
      @(negedge clk);
    end
    test_sb_empty("halt");
  endtask

  task automatic test_wrap();
    logic [4:0] exp_wrap;
    exp_wrap = 5'b00100;
    tick();
    Jump_En = 1'b1;
    Jump_Addr = 8'hFE;
    exp_q.push_back(8'hFE);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    tick();
    Jump_En = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (Wrap !== exp_wrap[i])
        $display("FAIL wrap_pulse[%0d]: got wrap=%b addr=%h, expected wrap=%b", i, Wrap, Address_Instruction_Bus, exp_wrap[i]);
      else passed++;
      if (i < 4) tick();
    end
    test_sb_empty("wrap");
  endtask

  task automatic test_priority_and_reset();
    tick();
    Jump_En = 1'b1;
    Halt = 1'b1;
    Jump_Addr = 8'h00;
    tick();
    Jump_En = 1'b0;
    Halt = 1'b0;
    @(negedge clk);
    checks++;
    if (Halted !== 1'b0 || Address_Instruction_Bus !== 8'h00 || Wrap !== 1'b0 || IR_Valid !== 1'b0)
      $display("FAIL jump_over_halt: got halted=%b addr=%h wrap=%b v=%b, expected halted=0 addr=00 wrap=0 v=0",
               Halted, Address_Instruction_Bus, Wrap, IR_Valid);
    else passed++;
    exp_q.push_back(8'h00);
    tick();
    @(negedge clk);
    tick();
    IR_Ready = 1'b0;
    @(negedge clk);
    test_sb_empty("priority");
    checks++;
    if (IR_Valid !== 1'b1 || IR_PC !== 8'h01)
      $display("FAIL stall_before_rst: got v=%b irpc=%h, expected v=1 irpc=01", IR_Valid, IR_PC);
    else passed++;
    sb_on = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({Address_Instruction_Bus, IR_Valid, Instruction_Reg, IR_PC, Halted, Wrap} !== '0)
      $display("FAIL async_reset: got addr=%h v=%b ir=%h irpc=%h halted=%b wrap=%b, expected all 0",
               Address_Instruction_Bus, IR_Valid, Instruction_Reg, IR_PC, Halted, Wrap);
    else passed++;
    IR_Ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_jump();
    test_halt();
    test_wrap();
    test_priority_and_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
